dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 93 +++++++++
 tb/tb_dmem_access_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sub-word load/store controller for a word-wide data memory without byte enables.
// Ports: clock, reset_n (sync, active-low); req_* handshake with a requester (valid/ready, write,
// size, unsigned, addr, wdata); rsp_valid/rsp_rdata/rsp_err completion pulse; mem_write/mem_addr/
// mem_wdata/mem_rdata word memory port whose read data arrives one cycle after the address.
// Sub-word stores are done as read-modify-write.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses complete immediately with rsp_err.
module dmem_access_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;
  state_t      state_q, state_d;
  logic        write_q, unsigned_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept, req_mis;
  logic [31:0] sh_b, sh_h, load_ext, lane_mask, lane_data, merged;
  assign accept = req_valid && (state_q == IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !accept ? IDLE : req_mis ? RSP : (req_write && req_size[1]) ? WR : RD;
      RD:      state_d = CAP;
      CAP:     state_d = write_q ? WR : RSP;
      WR:      state_d = RSP;
      default: state_d = IDLE;
    endcase
  end
  // Lane selection: byte lane is addr[1:0], half lane is addr[1]; addr[0] is ignored for halves.
  assign sh_b      = mem_rdata >> {addr_q[1:0], 3'b000};
  assign sh_h      = mem_rdata >> {addr_q[1], 4'b0000};
  assign load_ext  = (size_q == 2'b00) ? {{24{~unsigned_q & sh_b[7]}}, sh_b[7:0]} :
                     (size_q == 2'b01) ? {{16{~unsigned_q & sh_h[15]}}, sh_h[15:0]} : mem_rdata;
  assign lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << {addr_q[1:0], 3'b000}) :
                                         (32'h0000_FFFF << {addr_q[1], 4'b0000});
  assign lane_data = (size_q == 2'b00) ? (wdata_q << {addr_q[1:0], 3'b000}) :
                                         (wdata_q << {addr_q[1], 4'b0000});
  assign merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        err_q      <= req_mis;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rdata_q    <= '0;
      end
      // wdata_q is reused to hold the merged word so mem_wdata needs no extra register.
      if (state_q == CAP) begin
        if (write_q) wdata_q <= merged;
        else rdata_q <= load_ext;
      end
    end
  end
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_write = (state_q == WR);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed vector bench for dmem_access_ctrl with a word memory model.
module tb_dmem_access_ctrl;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic        bd_en = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  int          wr_count = 0, rsp_count = 0;
  int          checks = 0, failures = 0;
  dmem_access_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (bd_en) mem[bd_idx] <= bd_val;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
    if (mem_write) wr_count <= wr_count + 1;
    if (rsp_valid) rsp_count <= rsp_count + 1;
  end
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic [31:0] m;
    int          nw;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic set_mem(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clock);
    bd_en = 1'b1; bd_idx = idx; bd_val = val;
    @(posedge clock); #1;
    bd_en = 1'b0;
  endtask
  task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat, output int nw, output int wcyc);
    int w0;
    w0 = wr_count;
    wcyc = 0;
    @(negedge clock);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clock); #1;
    // junk request while busy must be ignored
    req_addr = 32'h3C; req_wdata = 32'hFFFF_FFFF; req_write = ~w; req_size = ~sz;
    for (lat = 1; lat < 20; lat++) begin
      if (mem_write && wcyc == 0) wcyc = lat;
      if (rsp_valid) break;
      if (req_ready) chk("ready_while_busy", {31'b0, req_ready}, 32'd0);
      @(posedge clock); #1;
      req_valid = 1'b0;
    end
    req_valid = 1'b0;
    if (lat >= 20) chk("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clock); #1;
    chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    chk("ready_after_rsp", {31'b0, req_ready}, 32'd1);
    nw = wr_count - w0;
  endtask
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, nw, wcyc, r0, w0;
    int          acc [4];
    int          rsp [4];
    int          na, nr;
    tbl[0]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_ABCD, 3, 32'hABCD_1234, 0};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_00AB, 3, 32'hABCD_1234, 0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0000_0034, 3, 32'hABCD_1234, 0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFF_FFCD, 3, 32'hABCD_1234, 0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_1234, 3, 32'hABCD_1234, 0};
    tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hABCD_1234, 3, 32'hABCD_1234, 0};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 32'h0, 4, 32'hABCD_5534, 1};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 32'h0, 4, 32'hBEEF_5534, 1};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_BEEF, 3, 32'hBEEF_5534, 0};
    tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 2, 32'h0, 1};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 3, 32'h0, 0};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h14, 32'hDEAD_BEEF, 32'h0, 2, 32'hDEAD_BEEF, 1};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'hFFFF_FFDE, 3, 32'hDEAD_BEEF, 0};
    tbl[13] = '{1'b0, 2'b00, 1'b1, 32'h16, 32'h0, 32'h0000_00AD, 3, 32'hDEAD_BEEF, 0};
    tbl[14] = '{1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h0000_DEAD, 3, 32'hDEAD_BEEF, 0};
    tbl[15] = '{1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 0};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    set_mem(6'd4, 32'hABCD_1234);
    for (int i = 0; i < 16; i++) begin
      run(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, rd, er, lat, nw, wcyc);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("v%0d_err", i), {31'b0, er}, 32'd0);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_writes", i), nw, tbl[i].nw);
      chk($sformatf("v%0d_wr_cycle", i), wcyc, (tbl[i].nw != 0) ? tbl[i].lat - 1 : 0);
      chk($sformatf("v%0d_mem", i), mem[tbl[i].a[7:2]], tbl[i].m);
    end
    // misaligned half store
    set_mem(6'd4, 32'hABCD_1234);
    run(1'b1, 2'b01, 1'b0, 32'h11, 32'hBEEF, rd, er, lat, nw, wcyc);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_sh_err", {31'b0, er}, 32'd1);
    chk("mis_sh_rdata", rd, 32'd0);
    chk("mis_sh_latency", lat, 32'd1);
    chk("mis_sh_writes", nw, 32'd0);
    chk("mis_sh_mem", mem[4], 32'hABCD_1234);
`else
    chk("mis_sh_err", {31'b0, er}, 32'd0);
    chk("mis_sh_latency", lat, 32'd4);
    chk("mis_sh_writes", nw, 32'd1);
    chk("mis_sh_mem", mem[4], 32'hABCD_BEEF);
`endif
    // reset asserted while a byte store sits in CAP
    set_mem(6'd4, 32'hABCD_1234);
    w0 = wr_count; r0 = rsp_count;
    @(negedge clock);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h11; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("abort_rd_mem_addr", mem_addr, 32'h10);
    @(posedge clock); #1;
    chk("abort_cap_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clock) reset_n = 1'b0;
    @(posedge clock); #1;
    chk("abort_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("abort_writes", wr_count - w0, 32'd0);
    chk("abort_rsp", rsp_count - r0, 32'd0);
    chk("abort_mem", mem[4], 32'hABCD_1234);
    // back-to-back loads with req_valid held high
    na = 0; nr = 0;
    @(negedge clock);
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (req_valid && req_ready && na < 4) begin acc[na] = t; na++; end
      if (rsp_valid && nr < 4) begin rsp[nr] = t; nr++; end
      if (rsp_valid && req_ready) chk("b2b_overlap", 32'd1, 32'd0);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", na, 32'd3);
    chk("b2b_rsps", nr, 32'd2);
    if (na >= 2 && nr >= 1) begin
      chk("b2b_first_latency", rsp[0] - acc[0], 32'd3);
      chk("b2b_second_accept", acc[1] - rsp[0], 32'd1);
    end
    for (int t = 0; t < 10 && !req_ready; t++) @(posedge clock);
    #1;
    chk("b2b_drain_ready", {31'b0, req_ready}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
